ps2_host_tx: RTL and testbench

- Host-to-device transmitter for the PS/2 keyboard port; the counterpart of the keyboard receiver that decodes device-to-host scan codes.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the shared open-drain PS2_KBCLK/PS2_KBDAT lines through output-enable pins.
- Reports done or error to the game control FSM.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_line_filter.sv | 29 ++
 rtl/ps2_host_tx.sv | 95 +++++++++
 tb/tb_ps2_host_tx.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, keyboard command bytes and parity helper.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, WAIT_FIRST, SHIFT, WAIT_IDLE, FAIL} state_t;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] ACK_CODE = 8'hFA;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-drain pin levels/enables of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic send;
  logic [7:0] tx_byte;
  logic busy;
  logic done;
  logic error;
  logic ps2_clk_in;
  logic ps2_dat_in;
  logic ps2_clk_oe;
  logic ps2_dat_oe;
  modport master (
    output send, tx_byte, ps2_clk_in, ps2_dat_in,
    input busy, done, error, ps2_clk_oe, ps2_dat_oe
  );
  modport slave (
    input send, tx_byte, ps2_clk_in, ps2_dat_in,
    output busy, done, error, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchroniser, FILTER_CYCLES glitch filter and falling-edge strobe for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic raw,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic accept;
  always_comb accept = (sync[1] != level) && (cnt == CW'(FILTER_CYCLES - 1));
  // cnt counts consecutive samples disagreeing with level; any agreeing sample restarts it
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      sync <= 2'b11;
      cnt <= '0;
      level <= 1'b1;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? sync[1] : level;
      fall <= accept && level;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device on the PS/2 keyboard port
// and reports done (ACK seen) or error (timeout / missing ACK).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT = 750000,
  parameter int FRAME_TIMEOUT = 100000,
  parameter int FILTER_CYCLES = 8
) (
  input logic CLOCK_50,
  input logic resetn,
  ps2_host_tx_if.slave bus
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  state_t state;
  logic [8:0] shift;
  logic [3:0] bitcnt;
  logic [TW-1:0] timer;
  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused, fail_now;
  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .raw(bus.ps2_clk_in), .level(clk_lvl), .fall(clk_fall)
  );
  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filt (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .raw(bus.ps2_dat_in), .level(dat_lvl), .fall(dat_fall_unused)
  );
  // the 11th fall (bitcnt 10) is where the device must hold data low as ACK
  always_comb fail_now = (state == WAIT_FIRST && !clk_fall && timer == '0)
                      || (state == SHIFT && (clk_fall ? (bitcnt == 4'd10 && dat_lvl) : timer == '0))
                      || (state == WAIT_IDLE && !(clk_lvl && dat_lvl) && timer == '0);
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      shift <= '0;
      bitcnt <= '0;
      timer <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.ps2_clk_oe <= 1'b0;
      bus.ps2_dat_oe <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      timer <= (timer == '0) ? '0 : timer - 1'b1;
      case (state)
        IDLE: if (bus.send && !bus.done) begin
          shift <= {odd_parity(bus.tx_byte), bus.tx_byte};
          timer <= TW'(INHIBIT_CYCLES - 1);
          bus.ps2_clk_oe <= 1'b1;
          bus.busy <= 1'b1;
          state <= INHIBIT;
        end
        INHIBIT: if (timer == '0) begin
          bus.ps2_dat_oe <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          timer <= TW'(START_TIMEOUT);
          bus.ps2_clk_oe <= 1'b0;
          state <= WAIT_FIRST;
        end
        WAIT_FIRST: if (clk_fall) begin
          bus.ps2_dat_oe <= ~shift[0];
          shift <= {1'b0, shift[8:1]};
          bitcnt <= 4'd1;
          timer <= TW'(FRAME_TIMEOUT);
          state <= SHIFT;
        end
        SHIFT: if (clk_fall) begin
          bitcnt <= bitcnt + 4'd1;
          if (bitcnt == 4'd10) state <= WAIT_IDLE;
          else if (bitcnt == 4'd9) bus.ps2_dat_oe <= 1'b0;
          else begin
            bus.ps2_dat_oe <= ~shift[0];
            shift <= {1'b0, shift[8:1]};
          end
        end
        WAIT_IDLE: if (clk_lvl && dat_lvl) begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        FAIL: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fail_now) begin
        bus.error <= 1'b1;
        bus.busy <= 1'b0;
        bus.ps2_clk_oe <= 1'b0;
        bus.ps2_dat_oe <= 1'b0;
        state <= FAIL;
      end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 keyboard model on scaled-down timeouts.
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 200;
  localparam int ST = 3000;
  localparam int FT = 2000;
  localparam int HP = 40;
  logic CLOCK_50 = 1'b0;
  logic resetn;
  logic dev_clk, dev_dat;
  int n_checks = 0, n_fail = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_busy_bad = 0;
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .FRAME_TIMEOUT(FT), .FILTER_CYCLES(8)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;
  always @(posedge CLOCK_50)
    if (resetn) begin
      if (bus.done) n_done++;
      if (bus.error) n_err++;
      if (bus.done && bus.error) n_both++;
      if ((bus.done || bus.error) && bus.busy) n_busy_bad++;
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask
  // keyboard model: samples start..parity at falls 1-10, stop in the following high phase, ACKs on fall 11
  task automatic dev_frame(input bit ack, input int glitch_at, input int nfalls, output logic [10:0] bits);
    bits = '1;
    for (int i = 0; i < nfalls; i++) begin
      if (i == 10) begin
        bits[10] = bus.ps2_dat_in;
        if (ack) dev_dat = 1'b0;
      end
      if (i == glitch_at) begin
        cycles(HP / 2);
        dev_clk = 1'b0;
        cycles(3);
        dev_clk = 1'b1;
        cycles(HP - HP / 2 - 3);
      end else cycles(HP);
      dev_clk = 1'b0;
      if (i < 10) bits[i] = bus.ps2_dat_in;
      cycles(HP);
      dev_clk = 1'b1;
    end
    if (nfalls == 11) begin
      cycles(HP);
      dev_dat = 1'b1;
    end
  endtask
  task automatic request(input logic [7:0] b, input int resend_at);
    int k;
    bus.tx_byte = b;
    bus.send = 1'b1;
    cycles(1);
    bus.send = 1'b0;
    bus.tx_byte = ~b;
    check("busy_after_send", bus.busy, 1);
    k = 0;
    while (bus.ps2_clk_oe && !bus.ps2_dat_oe && k < INH + 50) begin
      bus.send = (k == resend_at);
      if (k == resend_at) bus.tx_byte = b ^ 8'h5A;
      cycles(1);
      k++;
    end
    bus.send = 1'b0;
    check("inhibit_len", k, INH);
    check("req_both_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 2'b11);
    cycles(1);
    check("wait_first_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 2'b01);
  endtask
  task automatic run_frame(input logic [7:0] b, input bit ack, input int glitch_at, input int resend_at, input bit send_on_pulse);
    int nd, ne, k;
    logic [10:0] bits, exp;
    logic par;
    nd = n_done;
    ne = n_err;
    par = ($countones(b) % 2 == 0);
    exp = {1'b1, par, b, 1'b0};
    request(b, resend_at);
    dev_frame(ack, glitch_at, 11, bits);
    check("frame_bits", bits, exp);
    k = 0;
    while (!(bus.done || bus.error) && (n_done + n_err) == (nd + ne) && k < 400) begin
      cycles(1);
      k++;
    end
    if (send_on_pulse && bus.done) begin
      bus.send = 1'b1;
      bus.tx_byte = CMD_RESET;
      cycles(1);
      bus.send = 1'b0;
      check("send_on_done_ignored", {bus.busy, bus.ps2_clk_oe}, 0);
    end
    cycles(20);
    check("done_count", n_done - nd, ack ? 1 : 0);
    check("error_count", n_err - ne, ack ? 0 : 1);
    check("lines_released", {bus.busy, bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
  endtask
  initial begin
    logic [10:0] bits;
    int k, ne;
    resetn = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    bus.send = 1'b0;
    bus.tx_byte = 8'h00;
    cycles(4);
    check("reset_outputs", {bus.busy, bus.done, bus.error, bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    resetn = 1'b1;
    cycles(5);
    check("idle_outputs", {bus.busy, bus.done, bus.error, bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    run_frame(CMD_SET_LEDS, 1, -1, -1, 1);
    run_frame(8'h00, 1, -1, -1, 0);
    run_frame(8'h01, 1, -1, -1, 0);
    for (int i = 0; i < 3; i++) run_frame(8'($urandom), 1, -1, -1, 0);
    ne = n_err;
    request(CMD_ENABLE, -1);
    k = 0;
    while (!bus.error && k < ST + 50) begin
      cycles(1);
      k++;
    end
    check("start_timeout_window", (k >= ST - 1 && k <= ST + 3), 1);
    check("timeout_lines_released", {bus.busy, bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    cycles(5);
    check("timeout_error_count", n_err - ne, 1);
    run_frame(CMD_RESET, 0, -1, -1, 0);
    request(8'hA5, -1);
    dev_frame(1, -1, 5, bits);
    check("partial_bits", bits[4:0], 5'b01010);
    cycles(5);
    #3 resetn = 1'b0;
    #1 check("async_reset_release", {bus.busy, bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    cycles(3);
    resetn = 1'b1;
    cycles(5);
    run_frame(CMD_ENABLE, 1, -1, -1, 0);
    run_frame(8'h3C, 1, -1, 20, 0);
    run_frame(8'hC3, 1, 5, -1, 0);
    check("done_error_overlap", n_both, 0);
    check("busy_at_pulse", n_busy_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
